pc_unit: RTL

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_pkg.sv | 18 +
 rtl/pc_redir_buf.sv | 50 +++++
 rtl/pc_unit.sv | 124 ++++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: shared types and default parameters for the program-counter unit.
//   pc_state_e    - controller state (IDLE / RUN / PEND)
//   ADDR_W_DEF    - default PC width in bits
//   STEP_DEF      - default sequential increment in bytes
//   RESET_VEC_DEF - default fetch address after reset (truncated to ADDR_W)
package pc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } pc_state_e;

  localparam int          ADDR_W_DEF    = 32;
  localparam int          STEP_DEF      = 4;
  localparam logic [63:0] RESET_VEC_DEF = 64'd0;

endpackage

// File: rtl/pc_redir_buf.sv
// pc_redir_buf: holds one branch target captured while fetch is stalled.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   load          - capture load_target and mark valid (newest branch wins)
//   load_target   - target to capture
//   clear         - drop the entry and zero the stored target (flush/reset)
//   consume       - entry has been applied; drop valid, target left as is
//   valid         - registered: a captured target is waiting
//   target        - registered: the captured target
module pc_redir_buf import pc_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_target,
  input  logic              clear,
  input  logic              consume,
  output logic              valid,
  output logic [ADDR_W-1:0] target
);

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] target_q, target_d;

  // clear beats load: a flush in the same cycle as a stalled branch must
  // leave nothing behind.
  always_comb begin
    valid_d  = valid_q;
    target_d = target_q;
    if (rst || clear) begin
      valid_d  = 1'b0;
      target_d = '0;
    end else if (load) begin
      valid_d  = 1'b1;
      target_d = load_target;
    end else if (consume) begin
      valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    valid_q  <= valid_d;
    target_q <= target_d;
  end

  assign valid  = valid_q;
  assign target = target_q;

endmodule

// File: rtl/pc_unit.sv
// pc_unit: instruction fetch program counter with stall, branch and flush
// redirect. A branch taken while stalled is parked in pc_redir_buf and
// applied on the first unstalled edge.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   stall      - hold pc
//   flush      - redirect to flush_pc; beats stall and any pending branch
//   flush_pc   - flush target
//   br_valid   - branch/jump taken this cycle
//   br_target  - branch/jump target
//   pc         - registered fetch address
//   ce         - registered instruction-memory chip enable
//   redir_pend - a stalled branch target is waiting to be applied
//
// state | meaning
// IDLE  | in or just out of reset, ce=0, pc=RESET_VEC, inputs ignored
// RUN   | fetching, no pending redirect
// PEND  | fetching but stalled with a captured branch target
module pc_unit import pc_pkg::*; #(
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter int                STEP      = STEP_DEF,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(RESET_VEC_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  input  logic              br_valid,
  input  logic [ADDR_W-1:0] br_target,
  output logic [ADDR_W-1:0] pc,
  output logic              ce,
  output logic              redir_pend
);

  localparam logic [ADDR_W-1:0] STEP_W = ADDR_W'(STEP);

  pc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              ce_q, ce_d;

  logic              buf_load, buf_clear, buf_consume;
  logic              buf_valid;
  logic [ADDR_W-1:0] buf_target;

  pc_redir_buf #(.ADDR_W(ADDR_W)) u_redir_buf (
    .clk         (clk),
    .rst         (rst),
    .load        (buf_load),
    .load_target (br_target),
    .clear       (buf_clear),
    .consume     (buf_consume),
    .valid       (buf_valid),
    .target      (buf_target)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ce_d        = ce_q;
    buf_load    = 1'b0;
    buf_clear   = 1'b0;
    buf_consume = 1'b0;
    if (rst) begin
      state_d   = IDLE;
      pc_d      = RESET_VEC;
      ce_d      = 1'b0;
      buf_clear = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          // First fetch happens at RESET_VEC; advancing starts next edge.
          state_d = RUN;
          pc_d    = RESET_VEC;
          ce_d    = 1'b1;
        end
        RUN: begin
          if (flush) begin
            pc_d      = flush_pc;
            buf_clear = 1'b1;
          end else if (br_valid && stall) begin
            state_d  = PEND;
            buf_load = 1'b1;
          end else if (br_valid) begin
            pc_d = br_target;
          end else if (!stall) begin
            pc_d = pc_q + STEP_W;  // wraps modulo 2^ADDR_W
          end
        end
        PEND: begin
          if (flush) begin
            state_d   = RUN;
            pc_d      = flush_pc;
            buf_clear = 1'b1;
          end else if (stall) begin
            buf_load = br_valid;
          end else begin
            // A branch arriving on the release cycle is newer than the parked one.
            state_d     = RUN;
            pc_d        = br_valid ? br_target : buf_target;
            buf_consume = 1'b1;
          end
        end
        default: begin
          state_d   = IDLE;
          pc_d      = RESET_VEC;
          ce_d      = 1'b0;
          buf_clear = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    pc_q    <= pc_d;
    ce_q    <= ce_d;
  end

  assign pc         = pc_q;
  assign ce         = ce_q;
  assign redir_pend = buf_valid;

endmodule
